// File: rtl/find_bkt_lvl_ctrl.sv
// Backtrack-level search sequencer sitting downstream of the level-state group chain.
// Optional per-run statistics counters are enabled with the FIND_BKT_STATS_EN macro.
module find_bkt_lvl_ctrl #(
  parameter int NUM_GRPS  = 4,
  parameter int WIDTH_GRP = 2,
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_BIN = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH_LVL-1:0] max_lvl_i,
  output logic [WIDTH_GRP-1:0] grp_sel_o,
  output logic [1:0]           findflag_o,
  input  logic [1:0]           findflag_i,
  input  logic [3:0]           findindex_i,
  input  logic [WIDTH_BIN-1:0] bkt_bin_i,
  output logic                 apply_bkt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 no_bkt_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic [WIDTH_BIN-1:0] bkt_bin_o,
  output logic [1:0]           state_o
`ifdef FIND_BKT_STATS_EN
  ,
  output logic [31:0]          scan_cyc_o,
  output logic [15:0]          bkt_cnt_o
`endif
);

  // Handshake: start_i is accepted only in IDLE (no backpressure); the result
  // (no_bkt_o, bkt_lvl_o, bkt_bin_o) is valid in the single cycle done_o is high.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [WIDTH_GRP-1:0] grp_r;
  logic [1:0]           flag_r;
  logic                 no_bkt_r;
  logic [WIDTH_LVL-1:0] bkt_lvl_r;
  logic [WIDTH_BIN-1:0] bkt_bin_r;

  logic [WIDTH_LVL-1:0] max_grp;
  logic [WIDTH_GRP-1:0] start_grp;
  logic [1:0]           pos;
  logic                 found;

  always_comb begin
    max_grp = max_lvl_i >> 2;
    if (max_grp > WIDTH_LVL'(NUM_GRPS - 1)) start_grp = WIDTH_GRP'(NUM_GRPS - 1);
    else                                     start_grp = max_grp[WIDTH_GRP-1:0];
  end

  // Lowest set bit wins; an all-zero index maps to position 0.
  always_comb begin
    pos = 2'd0;
    if      (findindex_i[0]) pos = 2'd0;
    else if (findindex_i[1]) pos = 2'd1;
    else if (findindex_i[2]) pos = 2'd2;
    else if (findindex_i[3]) pos = 2'd3;
  end

  // Flag value 3 is treated the same as found (2).
  assign found = findflag_i[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grp_r     <= '0;
      flag_r    <= '0;
      no_bkt_r  <= 1'b0;
      bkt_lvl_r <= '0;
      bkt_bin_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            grp_r    <= start_grp;
            flag_r   <= 2'd0;
            no_bkt_r <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (found) begin
            bkt_lvl_r <= WIDTH_LVL'({grp_r, pos});
            bkt_bin_r <= bkt_bin_i;
            state     <= APPLY;
          end else if (grp_r != '0) begin
            grp_r  <= grp_r - WIDTH_GRP'(1);
            flag_r <= findflag_i;
          end else begin
            no_bkt_r <= 1'b1;
            state    <= DONE;
          end
        end
        APPLY:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign grp_sel_o   = (state == SCAN) ? grp_r  : '0;
  assign findflag_o  = (state == SCAN) ? flag_r : 2'd0;
  assign apply_bkt_o = (state == APPLY);
  assign done_o      = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign no_bkt_o    = no_bkt_r;
  assign bkt_lvl_o   = bkt_lvl_r;
  assign bkt_bin_o   = bkt_bin_r;
  assign state_o     = state;

`ifdef FIND_BKT_STATS_EN
  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cyc_o <= '0;
      bkt_cnt_o  <= '0;
    end else begin
      if (state == SCAN && scan_cyc_o != '1) scan_cyc_o <= scan_cyc_o + 32'd1;
      if (state == APPLY && bkt_cnt_o != '1) bkt_cnt_o <= bkt_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_find_bkt_lvl_ctrl.sv
// Scoreboard bench for find_bkt_lvl_ctrl: a table-driven group model answers the
// selected group, the driver queues expectations, a negedge monitor checks them.
module tb_find_bkt_lvl_ctrl;

  localparam int W_EXP = 35; // {no_bkt, lvl[15:0], bin[9:0], done_latency[7:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] max_lvl_i;
  logic [1:0]  grp_sel_o;
  logic [1:0]  findflag_o;
  logic [1:0]  findflag_i;
  logic [3:0]  findindex_i;
  logic [9:0]  bkt_bin_i;
  logic        apply_bkt_o;
  logic        busy_o;
  logic        done_o;
  logic        no_bkt_o;
  logic [15:0] bkt_lvl_o;
  logic [9:0]  bkt_bin_o;
  logic [1:0]  state_o;
`ifdef FIND_BKT_STATS_EN
  logic [31:0] scan_cyc_o;
  logic [15:0] bkt_cnt_o;
`endif

  find_bkt_lvl_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .max_lvl_i   (max_lvl_i),
    .grp_sel_o   (grp_sel_o),
    .findflag_o  (findflag_o),
    .findflag_i  (findflag_i),
    .findindex_i (findindex_i),
    .bkt_bin_i   (bkt_bin_i),
    .apply_bkt_o (apply_bkt_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .no_bkt_o    (no_bkt_o),
    .bkt_lvl_o   (bkt_lvl_o),
    .bkt_bin_o   (bkt_bin_o),
    .state_o     (state_o)
`ifdef FIND_BKT_STATS_EN
    ,
    .scan_cyc_o  (scan_cyc_o),
    .bkt_cnt_o   (bkt_cnt_o)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- group model ----------------
  logic [1:0] grp_flag [4];
  logic [3:0] grp_idx  [4];
  logic [9:0] grp_bin  [4];

  always_comb begin
    findflag_i  = grp_flag[grp_sel_o];
    findindex_i = grp_idx[grp_sel_o];
    bkt_bin_i   = grp_bin[grp_sel_o];
  end

  // ---------------- scoreboard ----------------
  logic [W_EXP-1:0] exp_q[$];
  logic [3:0]       exp_scan_q[$];
  logic [7:0]       exp_apply_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    $display("FAIL %s: DUT event with no expectation queued (cycle %0d)", name, cyc);
  endtask

  int               lat;
  logic [W_EXP-1:0] e;

  always @(negedge clk) begin
    lat = cyc - start_cyc;
    if (busy_o && !apply_bkt_o && !done_o) begin
      if (exp_scan_q.size() == 0) flag_fail("unexpected_scan");
      else check("scan_grp_flag", {grp_sel_o, findflag_o}, exp_scan_q.pop_front());
    end
    if (apply_bkt_o || done_o) check("sel_flag_outside_scan", {grp_sel_o, findflag_o}, 4'h0);
    if (apply_bkt_o) begin
      if (exp_apply_q.size() == 0) flag_fail("unexpected_apply");
      else check("apply_latency", lat, exp_apply_q.pop_front());
    end
    if (done_o) begin
      if (exp_q.size() == 0) flag_fail("unexpected_done");
      else begin
        e = exp_q.pop_front();
        check("done_latency", lat, e[7:0]);
        check("no_bkt", no_bkt_o, e[34]);
        if (!e[34]) begin
          check("bkt_lvl", bkt_lvl_o, e[33:18]);
          check("bkt_bin", bkt_bin_o, e[17:8]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_grps();
    for (int i = 0; i < 4; i++) begin
      grp_flag[i] = 2'd1;
      grp_idx[i]  = 4'd0;
      grp_bin[i]  = 10'd0;
    end
  endtask

  task automatic set_grp(input int g, input logic [1:0] f, input logic [3:0] idx, input logic [9:0] bin);
    grp_flag[g] = f;
    grp_idx[g]  = idx;
    grp_bin[g]  = bin;
  endtask

  task automatic exp_scan(input logic [1:0] g, input logic [1:0] f);
    exp_scan_q.push_back({g, f});
  endtask

  task automatic issue(input logic [15:0] max, input logic nb, input logic [15:0] lvl,
                       input logic [9:0] bin, input int apply_lat, input int done_lat, input bit hold);
    bit got;
    exp_q.push_back({nb, lvl, bin, 8'(done_lat)});
    if (apply_lat > 0) exp_apply_q.push_back(8'(apply_lat));
    @(negedge clk);
    start_i   = 1'b1;
    max_lvl_i = max;
    start_cyc = cyc;
    @(negedge clk);
    start_i   = hold;
    max_lvl_i = 16'hFFFF;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    if (!got) begin
      n_checks++;
      $display("FAIL done_timeout: done_o not seen within 40 cycles, required by latency %0d", done_lat);
      exp_q.delete();
      exp_scan_q.delete();
      exp_apply_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    start_i = 1'b0;
    max_lvl_i = 16'd0;
    clear_grps();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {grp_sel_o, findflag_o, apply_bkt_o, busy_o, done_o, no_bkt_o, bkt_lvl_o, bkt_bin_o}, 64'd0);
    rst = 1'b1;

    // max 6: group 1 searching, group 0 found at position 2
    clear_grps();
    set_grp(0, 2'd2, 4'b0100, 10'h05A);
    exp_scan(2'd1, 2'd0); exp_scan(2'd0, 2'd1);
    issue(16'd6, 1'b0, 16'd2, 10'h05A, 3, 4, 1'b0);

    // max 9, nothing found in groups 2,1,0 (back-to-back with the previous run)
    clear_grps();
    exp_scan(2'd2, 2'd0); exp_scan(2'd1, 2'd1); exp_scan(2'd0, 2'd1);
    issue(16'd9, 1'b1, 16'd0, 10'd0, 0, 4, 1'b0);

`ifdef FIND_BKT_STATS_EN
    check("scan_cyc", scan_cyc_o, 64'd5);
    check("bkt_cnt", bkt_cnt_o, 64'd1);
`endif

    // max 13: found immediately in group 3 at position 1
    clear_grps();
    set_grp(3, 2'd2, 4'b0010, 10'h3FF);
    exp_scan(2'd3, 2'd0);
    issue(16'd13, 1'b0, 16'd13, 10'h3FF, 2, 3, 1'b0);

    // max 40 clamps to group 3; group 3 above max, group 2 searching, group 1 found pos 3
    clear_grps();
    set_grp(3, 2'd0, 4'b0000, 10'h000);
    set_grp(1, 2'd2, 4'b1000, 10'h123);
    exp_scan(2'd3, 2'd0); exp_scan(2'd2, 2'd0); exp_scan(2'd1, 2'd1);
    issue(16'd40, 1'b0, 16'd7, 10'h123, 4, 5, 1'b0);

    // flag 3 acts as found; non-one-hot index picks lowest bit
    clear_grps();
    set_grp(0, 2'd3, 4'b1010, 10'h001);
    exp_scan(2'd0, 2'd0);
    issue(16'd3, 1'b0, 16'd1, 10'h001, 2, 3, 1'b0);

    // all-zero index -> position 0
    clear_grps();
    set_grp(1, 2'd2, 4'b0000, 10'h200);
    exp_scan(2'd1, 2'd0);
    issue(16'd5, 1'b0, 16'd4, 10'h200, 2, 3, 1'b0);

    // single group scanned, no backtrack
    clear_grps();
    exp_scan(2'd0, 2'd0);
    issue(16'd0, 1'b1, 16'd0, 10'd0, 0, 2, 1'b0);

    // start held high (with a changing max) throughout the scan is ignored
    clear_grps();
    exp_scan(2'd2, 2'd0); exp_scan(2'd1, 2'd1); exp_scan(2'd0, 2'd1);
    issue(16'd9, 1'b1, 16'd0, 10'd0, 0, 4, 1'b1);

    // reset in the middle of a scan: outputs clear, no apply or done follows
    clear_grps();
    set_grp(0, 2'd2, 4'b0001, 10'h0AA);
    exp_scan(2'd2, 2'd0); exp_scan(2'd1, 2'd1);
    @(negedge clk);
    start_i   = 1'b1;
    max_lvl_i = 16'd9;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_scan_reset_outputs",
          {grp_sel_o, findflag_o, apply_bkt_o, busy_o, done_o, no_bkt_o, bkt_lvl_o, bkt_bin_o}, 64'd0);
    rst = 1'b1;

    // start one cycle after reset release is accepted
    clear_grps();
    set_grp(3, 2'd2, 4'b0010, 10'h3FF);
    exp_scan(2'd3, 2'd0);
    issue(16'd13, 1'b0, 16'd13, 10'h3FF, 2, 3, 1'b0);

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 64'd0);
    check("exp_scan_q_drained", exp_scan_q.size(), 64'd0);
    check("exp_apply_q_drained", exp_apply_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/find_bkt_lvl_ctrl.md
Name: find_bkt_lvl_ctrl

Overview:
- Sequencer that sits directly downstream of the level-state group chain (one group = 4 levels).
- On a conflict it scans the groups from the one holding max_lvl down to group 0, propagating the search flag between groups.
- When a group reports found, it converts the one-hot index into the backtrack level and captures that group's bin.
- It then issues a one-cycle apply_bkt pulse back to all level-state groups, or reports that no backtrack exists (UNSAT at this engine).

Parameters:
- NUM_GRPS, 4, number of level-state groups; total levels = 4*NUM_GRPS.
- WIDTH_GRP, 2, width of group select; must be at least clog2(NUM_GRPS).
- WIDTH_LVL, 16, level width.
- WIDTH_BIN, 10, bin number width.

Ports:
- clk  in  1  clock
- rst  in  1  one clock; reset is synchronous and active-low
- start_i  in  1  start search; sampled only in IDLE
- max_lvl_i  in  WIDTH_LVL  highest level involved in the conflict; sampled with start_i
- grp_sel_o  out  WIDTH_GRP  group currently being scanned
- findflag_o  out  2  flag driven into the selected group (0 = above max, 1 = searching, 2 = found)
- findflag_i  in  2  flag returned by the selected group; combinational, same cycle
- findindex_i  in  4  one-hot position of the found level within the group
- bkt_bin_i  in  WIDTH_BIN  bin of the found level, from the selected group
- apply_bkt_o  out  1  one-cycle pulse that commits the backtrack in the groups
- busy_o  out  1  high from the cycle after start until done
- done_o  out  1  one-cycle result-valid pulse
- no_bkt_o  out  1  valid with done_o; 1 = nothing left to backtrack
- bkt_lvl_o  out  WIDTH_LVL  backtrack level; held until the next start
- bkt_bin_o  out  WIDTH_BIN  bin of the backtrack level; held until the next start

Behaviour:
- Reset (rst=0 at a clk edge) forces state IDLE. All outputs go to 0: grp_sel_o, findflag_o, apply_bkt_o, busy_o, done_o, no_bkt_o, bkt_lvl_o, bkt_bin_o. Reset overrides any state, including mid-scan; no apply_bkt_o is emitted after a reset.
- FSM states: IDLE, SCAN, APPLY, DONE.
- IDLE:
  - start_i=1: grp_r <= max_lvl_i>>2, clamped to NUM_GRPS-1 if larger; flag_r <= 0; go to SCAN.
  - Otherwise stay in IDLE.
- SCAN: drives grp_sel_o=grp_r and findflag_o=flag_r. Samples findflag_i / findindex_i / bkt_bin_i in the same cycle.
  - findflag_i==2: bkt_lvl_o <= grp_r*4 + pos(findindex_i), where pos = bit index 0..3. bkt_bin_o <= bkt_bin_i. Go to APPLY.
  - findflag_i!=2 and grp_r>0: grp_r <= grp_r-1; flag_r <= findflag_i. Stay in SCAN.
  - findflag_i!=2 and grp_r==0: no_bkt_r <= 1. Go to DONE, skipping APPLY.
  - findflag_i==3 is treated as 2.
- APPLY: apply_bkt_o=1 for exactly one cycle; go to DONE.
- DONE: done_o=1 for one cycle; no_bkt_o is valid in the same cycle; go to IDLE.
- no_bkt_o clears on the next accepted start.
- busy_o = state is SCAN, APPLY or DONE.
- start_i is ignored unless in IDLE. Back-to-back operation: start may be asserted in the cycle after done_o.
- Latency from start to done_o:
  - found in the k-th scanned group: k+2 cycles after the start cycle;
  - no backtrack: G+1 cycles, where G = number of groups scanned.
- A findindex_i that is not one-hot while findflag_i==2 uses the lowest set bit. All-zero findindex_i yields pos 0.
- grp_sel_o and findflag_o are 0 outside SCAN.

Optional Feature:
- Macro FIND_BKT_STATS_EN.
- Defined: adds outputs scan_cyc_o[31:0] and bkt_cnt_o[15:0].
  - scan_cyc_o increments on every SCAN cycle.
  - bkt_cnt_o increments on every apply_bkt_o pulse.
  - Both saturate and never wrap. Both reset to 0.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- max_lvl_i=6, NUM_GRPS=4; model returns findflag_i=1 for group 1, then 2 with findindex_i=4'b0100 and bkt_bin_i=10'h05A for group 0 -> grp_sel_o sequence 1,0; findflag_o sequence 0,1; apply_bkt_o on cycle 3; done_o on cycle 4; bkt_lvl_o=2, bkt_bin_o=0x05A, no_bkt_o=0.
- max_lvl_i=13; group 3 returns 2 with findindex_i=4'b0010 and bin 0x3FF -> one SCAN cycle only; bkt_lvl_o=13, bkt_bin_o=0x3FF; done_o 3 cycles after start.
- max_lvl_i=9; every group returns findflag_i=1 -> groups 2,1,0 scanned; no apply_bkt_o; done_o with no_bkt_o=1 on cycle 4.
- max_lvl_i=40 (beyond range) -> scan starts at grp_sel_o=3.
- start_i held high during SCAN -> ignored. Reset asserted mid-SCAN -> all outputs 0 on the next cycle and no apply_bkt_o. A start 1 cycle after reset release is accepted.
- With FIND_BKT_STATS_EN: run the first and third scenarios back-to-back -> scan_cyc_o=5, bkt_cnt_o=1.
